// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared types and defaults for the instruction-fetch stage
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    FS_REQ  = 2'd0,
    FS_WAIT = 2'd1,
    FS_HELD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
  } fd_t;

endpackage

// File: rtl/fetch_stage_fd_reg.sv
// rtl/fetch_stage_fd_reg.sv - F/D pipeline register with enable and synchronous reset
module fd_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  fd_t  d,
  output fd_t  q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '{instr: NOP_INSTR, pc: 32'h0, valid: 1'b0};
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS fetch stage: PC_F, single-outstanding IM handshake, F/D register
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc,
  input  logic        stall_D,
  output logic [31:0] PC_F,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  input  logic        im_rvalid,
  output logic [31:0] instr_D,
  output logic [31:0] PC_D,
  output logic        valid_D,
  output logic        fetch_busy
);

  fetch_state_t state, state_next;
  logic         drop_pending;
  logic [31:0]  hold_buf;
  logic         ready;
  logic         advance;
  fd_t          fd_d;
  fd_t          fd_q;

  assign ready      = (state == FS_WAIT && im_rvalid && !drop_pending) || (state == FS_HELD);
  assign fetch_busy = !ready;
  assign advance    = ready && !stall_D && !reset;

  // A request left in flight by reset must drain before S_REQ may issue again,
  // otherwise two requests would be outstanding and the stale word mistaken for new.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= FS_REQ;
      drop_pending <= (state == FS_WAIT || drop_pending) && !im_rvalid;
    end else begin
      state <= state_next;
      if (im_rvalid) drop_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      PC_F     <= RESET_PC;
      hold_buf <= 32'h0;
    end else begin
      if (advance) PC_F <= npc;
      if (state == FS_WAIT && im_rvalid && !drop_pending && stall_D) hold_buf <= im_rdata;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FS_REQ:  if (!drop_pending) state_next = FS_WAIT;
      FS_WAIT: begin
        if (im_rvalid) begin
          if (drop_pending) state_next = FS_REQ;
          else if (stall_D) state_next = FS_HELD;
        end
      end
      FS_HELD: if (advance) state_next = FS_WAIT;
      default: state_next = FS_REQ;
    endcase
  end

  always_comb begin
    im_req  = 1'b0;
    im_addr = PC_F;
    case (state)
      FS_REQ:  im_req = !drop_pending && !reset;
      FS_WAIT, FS_HELD: begin
        if (advance) begin
          im_req  = 1'b1;
          im_addr = npc;
        end
      end
      default: im_req = 1'b0;
    endcase
  end

  assign fd_d = '{instr: (state == FS_HELD) ? hold_buf : im_rdata, pc: PC_F, valid: 1'b1};

  fd_reg #(.NOP_INSTR(NOP_INSTR)) u_fd_reg (
    .clk   (clk),
    .reset (reset),
    .en    (advance),
    .d     (fd_d),
    .q     (fd_q)
  );

  assign instr_D = fd_q.instr;
  assign PC_D    = fd_q.pc;
  assign valid_D = fd_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage with a randomized-latency IM model
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] npc;
  logic        stall_D;
  logic [31:0] PC_F;
  logic        im_req;
  logic [31:0] im_addr;
  logic [31:0] im_rdata;
  logic        im_rvalid;
  logic [31:0] instr_D;
  logic [31:0] PC_D;
  logic        valid_D;
  logic        fetch_busy;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .npc        (npc),
    .stall_D    (stall_D),
    .PC_F       (PC_F),
    .im_req     (im_req),
    .im_addr    (im_addr),
    .im_rdata   (im_rdata),
    .im_rvalid  (im_rvalid),
    .instr_D    (instr_D),
    .PC_D       (PC_D),
    .valid_D    (valid_D),
    .fetch_busy (fetch_busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Environment next-PC unit: a branch sits at every word with addr[5:2]==1.
  logic br_en;
  function automatic logic is_branch(input logic [31:0] a);
    return a[5:2] == 4'd1;
  endfunction
  function automatic logic [31:0] br_target(input logic [31:0] a);
    return {a[31:6], 6'b0} + 32'h400;
  endfunction

  assign npc = (valid_D && br_en && is_branch(PC_D)) ? br_target(PC_D) : PC_F + 32'd4;

  // Reference model: architectural fetch order with one delay slot after each branch.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t        sb_q[$];
  logic [31:0] m_cur, m_prev_pc;
  logic        m_prev_v;

  task automatic model_reset();
    m_cur    = 32'h0000_3000;
    m_prev_pc = 32'h0;
    m_prev_v = 1'b0;
  endtask

  task automatic push_expected(input int n);
    logic [31:0] nxt;
    for (int i = 0; i < n; i++) begin
      sb_q.push_back('{pc: m_cur, instr: mem_word(m_cur)});
      nxt = (m_prev_v && br_en && is_branch(m_prev_pc)) ? br_target(m_prev_pc) : m_cur + 32'd4;
      m_prev_pc = m_cur;
      m_prev_v  = 1'b1;
      m_cur     = nxt;
    end
  endtask

  // Monitor: pops one expected entry per advance seen in the previous cycle.
  logic fire        = 1'b0;
  logic fired_since = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (fire) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_advance actual_pc_d=%h required=none", PC_D);
        end else begin
          e = sb_q.pop_front();
          chk("pc_d", PC_D, e.pc);
          chk("instr_d", instr_D, e.instr);
        end
        fired_since = 1'b1;
      end
      chk("valid_d", {31'b0, valid_D}, {31'b0, fired_since});
      #3;
      fire = !reset && !fetch_busy && !stall_D;
      if (reset) fired_since = 1'b0;
    end
  end

  // Instruction memory: one response slot, latency drawn from [lat_min, lat_max].
  int          lat_min = 1;
  int          lat_max = 1;
  logic        pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = 32'h0;
  logic [31:0] last_addr = 32'h0;
  logic        exp_reset_addr = 1'b0;

  initial begin
    im_rvalid = 1'b0;
    im_rdata  = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      im_rvalid = 1'b0;
      im_rdata  = $urandom;
      if (pend) begin
        if (pend_cnt == 0) begin
          im_rvalid = 1'b1;
          im_rdata  = mem_word(pend_addr);
          pend      = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (reset) begin
        exp_reset_addr = 1'b1;
      end else if (im_req) begin
        chk("single_outstanding", {31'b0, pend}, 32'h0);
        if (exp_reset_addr) chk("first_addr_after_reset", im_addr, 32'h0000_3000);
        else if (br_en && last_addr == 32'h0000_3008) chk("redirect_addr", im_addr, 32'h0000_3400);
        exp_reset_addr = 1'b0;
        last_addr = im_addr;
        pend      = 1'b1;
        pend_addr = im_addr;
        pend_cnt  = $urandom_range(lat_max, lat_min) - 1;
      end
    end
  end

  task automatic do_reset();
    #1;
    reset   = 1'b1;
    stall_D = 1'b1;
    @(negedge clk);
    @(negedge clk);
    sb_q.delete();
    model_reset();
  endtask

  // mode 0: no stall, 1: random stall, 2: stall cycles 2..4
  task automatic run_phase(input int n, input int mode, output int cyc, output int busy);
    int remaining;
    remaining = n;
    cyc  = 0;
    busy = 0;
    push_expected(n);
    while (remaining > 0 && cyc < 2000) begin
      #1;
      reset = 1'b0;
      case (mode)
        1:       stall_D = ($urandom_range(3, 0) == 0);
        2:       stall_D = (cyc >= 2 && cyc <= 4);
        default: stall_D = 1'b0;
      endcase
      #1;
      if (mode == 2 && cyc >= 2 && cyc <= 4) chk("held_no_req", {31'b0, im_req}, 32'h0);
      if (mode == 2 && cyc == 5) begin
        chk("release_req", {31'b0, im_req}, 32'h1);
        chk("release_addr", im_addr, 32'h0000_3008);
      end
      if (fetch_busy) busy++;
      if (!fetch_busy && !stall_D) remaining--;
      cyc++;
      @(negedge clk);
    end
    chk("phase_remaining", remaining, 32'h0);
    #1;
    stall_D = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int cyc, busy, fired;
    logic done;
    reset   = 1'b1;
    stall_D = 1'b1;
    br_en   = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();
    chk("rst_pc_f", PC_F, 32'h0000_3000);
    chk("rst_pc_d", PC_D, 32'h0);
    chk("rst_instr_d", instr_D, 32'h0);
    chk("rst_valid_d", {31'b0, valid_D}, 32'h0);
    chk("rst_fetch_busy", {31'b0, fetch_busy}, 32'h1);

    lat_min = 1; lat_max = 1;
    run_phase(4, 0, cyc, busy);
    chk("lat1_cycles", cyc, 5);
    chk("lat1_busy", busy, 1);

    do_reset();
    lat_min = 3; lat_max = 3;
    run_phase(4, 0, cyc, busy);
    chk("lat3_cycles", cyc, 13);
    chk("lat3_busy", busy, 9);

    do_reset();
    lat_min = 1; lat_max = 1;
    run_phase(3, 2, cyc, busy);

    do_reset();
    br_en = 1'b1;
    lat_min = 1; lat_max = 3;
    run_phase(40, 1, cyc, busy);

    do_reset();
    br_en = 1'b0;
    lat_min = 1; lat_max = 1;
    run_phase(6, 0, cyc, busy);

    // Stale response: 0x3010 in flight across reset, returning after reset is released.
    do_reset();
    lat_min = 6; lat_max = 6;
    run_phase(4, 0, cyc, busy);
    do_reset();
    run_phase(2, 0, cyc, busy);

    // Reset coincident with an advance.
    do_reset();
    lat_min = 1; lat_max = 1;
    push_expected(6);
    fired = 0;
    done  = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      #1;
      reset   = 1'b0;
      stall_D = 1'b0;
      #1;
      if (!fetch_busy) begin
        if (fired == 3) begin
          reset = 1'b1;
          done  = 1'b1;
        end else begin
          fired++;
        end
      end
      @(negedge clk);
    end
    chk("rst_adv_reached", {31'b0, done}, 32'h1);
    chk("rst_adv_pc_f", PC_F, 32'h0000_3000);
    chk("rst_adv_valid_d", {31'b0, valid_D}, 32'h0);
    chk("rst_adv_instr_d", instr_D, 32'h0);
    chk("rst_adv_pc_d", PC_D, 32'h0);
    do_reset();
    run_phase(3, 0, cyc, busy);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", sb_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
